credit_payout_ctrl: RTL and testbench
=====================================

CREDIT_PAYOUT_CTRL -- requirements
Module: credit_payout_ctrl

Interface
REQ-001 Parameter: MAX_CREDIT, default 20, maximum credit held, in units of 100 colones (1..255).
REQ-002 Parameter: ACK_TIMEOUT, default 1000, clk cycles a hopper request waits for acknowledge before fault (>=2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 coin_100  input  1  one-cycle pulse, validated 100-colon coin inserted (value 1 unit).
REQ-006 coin_500  input  1  one-cycle pulse, validated 500-colon coin inserted (value 5 units).
REQ-007 price  input  8  product price in units, sampled only on the buy_req cycle.
REQ-008 buy_req  input  1  one-cycle pulse, request to debit price from credit.
REQ-009 payout_req  input  1  one-cycle pulse, return all remaining credit as change.
REQ-010 hopper_ack  input  1  one-cycle pulse, hopper has ejected the currently requested coin.
REQ-011 fault_clr  input  1  one-cycle pulse, leave FAULT state.
REQ-012 credit  output  8  current registered credit in units.
REQ-013 buy_ok / buy_nok  output  1 each  registered one-cycle purchase result pulses.
REQ-014 coin_reject  output  1  registered one-cycle pulse, inserted coin(s) not credited and must be returned mechanically.
REQ-015 pay_500 / pay_100  output  1 each  hopper request levels, at most one high, held until hopper_ack or timeout.
REQ-016 busy  output  1  high in every state other than IDLE.
REQ-017 fault  output  1  high in FAULT state only.

Function
REQ-018 States: IDLE, PAY_SEL, WAIT_500, WAIT_100, FAULT; the block SHALL enter IDLE on reset.
REQ-019 IDLE, coins: incoming value v = coin_100*1 + coin_500*5, added to credit at the next edge if (credit after same-cycle debit) + v <= MAX_CREDIT; otherwise neither coin is credited and coin_reject pulses.
REQ-020 IDLE, buy_req: if price != 0 and price <= credit (pre-update value), credit decreases by price and buy_ok pulses the next cycle; otherwise credit unchanged and buy_nok pulses.
REQ-021 IDLE priority: buy_req over payout_req; payout_req on a buy_req cycle is ignored.
REQ-022 IDLE, payout_req without buy_req: go to PAY_SEL; if credit is 0, PAY_SEL returns to IDLE next cycle with no hopper request.
REQ-023 PAY_SEL: credit >= 5 -> WAIT_500 with pay_500=1; else credit >= 1 -> WAIT_100 with pay_100=1; else -> IDLE.
REQ-024 WAIT_500/WAIT_100: on hopper_ack drop request, decrement credit by 5/1, go to PAY_SEL; one coin per request, greedy 500-first order.
REQ-025 Timeout: a counter cleared on entering WAIT_*; if it reaches ACK_TIMEOUT without hopper_ack, drop request, go to FAULT, credit unchanged.
REQ-026 hopper_ack outside WAIT_* SHALL be ignored.
REQ-027 Coins arriving in any state other than IDLE SHALL be rejected (coin_reject pulse), credit unchanged; buy_req there SHALL produce buy_nok; payout_req there is ignored.
REQ-028 FAULT: hold credit; fault_clr -> IDLE (credit retained, not paid out automatically).
REQ-029 credit SHALL never exceed MAX_CREDIT nor wrap below 0.

Reset
REQ-030 During rst: state IDLE, credit 0, timeout counter 0, pay_500, pay_100, buy_ok, buy_nok, coin_reject, fault all 0, busy 0.
REQ-031 Reset mid-payout SHALL drop the hopper request immediately (asynchronously) and discard remaining credit.

Verification
REQ-032 coin_500, coin_100, coin_100 in IDLE -> credit 7; buy_req price=4 -> buy_ok next cycle, credit 3.
REQ-033 credit 7, payout_req, hopper acks after 3 cycles each -> sequence pay_500, pay_100, pay_100; credit 7->2->1->0; back to IDLE, busy 0.
REQ-034 credit 18 (MAX 20), coin_100 and coin_500 same cycle -> coin_reject, credit 18; coin_100 alone -> credit 19.
REQ-035 credit 3, buy_req price=5 -> buy_nok, credit 3; buy_req price=0 -> buy_nok.
REQ-036 credit 6, payout_req, no hopper_ack for ACK_TIMEOUT cycles -> pay_500 drops, fault=1, credit 6; fault_clr -> IDLE, credit 6; coin_100 during WAIT_500 rejected.
REQ-037 credit 4, buy_req price=4 with coin_100 same cycle -> buy_ok, credit 1; rst asserted during WAIT_100 -> pay_100 low same cycle, credit 0.

Source files
------------

// File: rtl/credit_payout_ctrl.sv
// Coin-credit accumulator and change-payout controller for a vending machine.
// Credits 100/500 coins, debits purchases, and pays change coin by coin through a hopper.
module credit_payout_ctrl #(
  parameter int unsigned MAX_CREDIT  = 20,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [7:0] price,
  input  logic       buy_req,
  input  logic       payout_req,
  input  logic       hopper_ack,
  input  logic       fault_clr,
  output logic [7:0] credit,
  output logic       buy_ok,
  output logic       buy_nok,
  output logic       coin_reject,
  output logic       pay_500,
  output logic       pay_100,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [8:0]  MAX9     = 9'(MAX_CREDIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PAY_SEL  = 3'd1,
    WAIT_500 = 3'd2,
    WAIT_100 = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          buy_ok_q, buy_ok_d;
  logic          buy_nok_q, buy_nok_d;
  logic          reject_q, reject_d;

  logic          coin_any;
  logic          buy_good;
  logic [8:0]    coin_val;
  logic [8:0]    debited;
  logic [8:0]    sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      cnt_q     <= '0;
      buy_ok_q  <= 1'b0;
      buy_nok_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      buy_ok_q  <= buy_ok_d;
      buy_nok_q <= buy_nok_d;
      reject_q  <= reject_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    cnt_d     = cnt_q;
    buy_ok_d  = 1'b0;
    buy_nok_d = 1'b0;
    reject_d  = 1'b0;

    coin_any = coin_100 | coin_500;
    coin_val = 9'(coin_100) + (coin_500 ? 9'd5 : 9'd0);
    buy_good = buy_req && (price != 8'd0) && (price <= credit_q);
    // Coin acceptance is judged against the credit left after a same-cycle purchase.
    debited  = {1'b0, credit_q} - (buy_good ? {1'b0, price} : 9'd0);
    sum      = debited + coin_val;

    if (state_q != IDLE) begin
      reject_d  = coin_any;
      buy_nok_d = buy_req;
    end

    case (state_q)
      IDLE: begin
        buy_ok_d  = buy_good;
        buy_nok_d = buy_req && !buy_good;
        if (sum <= MAX9) begin
          credit_d = sum[7:0];
        end else begin
          credit_d = debited[7:0];
          reject_d = coin_any;
        end
        if (!buy_req && payout_req) state_d = PAY_SEL;
      end
      PAY_SEL: begin
        cnt_d = '0;
        if (credit_q >= 8'd5)       state_d = WAIT_500;
        else if (credit_q != 8'd0)  state_d = WAIT_100;
        else                        state_d = IDLE;
      end
      WAIT_500, WAIT_100: begin
        if (hopper_ack) begin
          credit_d = credit_q - ((state_q == WAIT_500) ? 8'd5 : 8'd1);
          state_d  = PAY_SEL;
        end else if (cnt_q == TMO_LAST) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hopper requests decode straight from state so reset drops them asynchronously.
  assign pay_500     = (state_q == WAIT_500);
  assign pay_100     = (state_q == WAIT_100);
  assign busy        = (state_q != IDLE);
  assign fault       = (state_q == FAULT);
  assign credit      = credit_q;
  assign buy_ok      = buy_ok_q;
  assign buy_nok     = buy_nok_q;
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_credit_payout_ctrl.sv
// Directed bench for credit_payout_ctrl with hand-computed expected values.
module tb_credit_payout_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_100, coin_500, buy_req, payout_req, hopper_ack, fault_clr;
  logic [7:0] price;
  logic [7:0] credit;
  logic       buy_ok, buy_nok, coin_reject, pay_500, pay_100, busy, fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  credit_payout_ctrl #(.MAX_CREDIT(20), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .coin_100(coin_100), .coin_500(coin_500),
    .price(price), .buy_req(buy_req), .payout_req(payout_req),
    .hopper_ack(hopper_ack), .fault_clr(fault_clr), .credit(credit),
    .buy_ok(buy_ok), .buy_nok(buy_nok), .coin_reject(coin_reject),
    .pay_500(pay_500), .pay_100(pay_100), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic c100, input logic c500);
    coin_100 = c100; coin_500 = c500;
    step();
    coin_100 = 1'b0; coin_500 = 1'b0;
  endtask

  task automatic buy(input logic [7:0] p);
    price = p; buy_req = 1'b1;
    step();
    buy_req = 1'b0; price = '0;
  endtask

  task automatic ack_after_3();
    step(); step();
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; coin_100 = 0; coin_500 = 0; price = '0; buy_req = 0;
    payout_req = 0; hopper_ack = 0; fault_clr = 0;
    #1;
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_pay", {pay_500, pay_100}, 0);
    check("rst_pulses", {buy_ok, buy_nok, coin_reject, fault}, 0);
    #12 rst = 1'b0;
    step();

    // Basic accumulate and purchase
    ins(0, 1); ins(1, 0); ins(1, 0);
    check("acc_7", credit, 7);
    buy(8'd4);
    check("buy4_ok", buy_ok, 1);
    check("buy4_credit", credit, 3);
    step();
    check("buy_ok_pulse", buy_ok, 0);

    // Ack outside WAIT is ignored
    hopper_ack = 1'b1; step(); hopper_ack = 1'b0;
    check("idle_ack", {busy, credit}, {1'b0, 8'd3});

    // Greedy payout of 7
    repeat (4) ins(1, 0);
    check("acc_7b", credit, 7);
    payout_req = 1'b1; step(); payout_req = 1'b0;
    check("paysel_busy", {busy, pay_500, pay_100}, 3'b100);
    step();
    check("req_500", {pay_500, pay_100}, 2'b10);
    ack_after_3();
    check("after_500", {pay_500, credit}, {1'b0, 8'd2});
    step();
    check("req_100a", {pay_500, pay_100}, 2'b01);
    ack_after_3();
    check("after_100a", credit, 1);
    step();
    check("req_100b", {pay_500, pay_100}, 2'b01);
    ack_after_3();
    check("after_100b", credit, 0);
    step();
    check("pay_done", {busy, pay_500, pay_100}, 3'b000);

    // Payout with zero credit returns without a hopper request
    payout_req = 1'b1; step(); payout_req = 1'b0;
    step();
    check("zero_payout", {busy, pay_500, pay_100}, 3'b000);

    // Credit ceiling
    repeat (3) ins(0, 1);
    repeat (3) ins(1, 0);
    check("acc_18", credit, 18);
    ins(1, 1);
    check("both_reject", {coin_reject, credit}, {1'b1, 8'd18});
    ins(1, 0);
    check("acc_19", {coin_reject, credit}, {1'b0, 8'd19});
    ins(1, 0);
    check("acc_20", credit, 20);
    ins(1, 0);
    check("over_max", {coin_reject, credit}, {1'b1, 8'd20});

    // Purchase rejection
    buy(8'd17);
    check("buy17", {buy_ok, credit}, {1'b1, 8'd3});
    buy(8'd5);
    check("buy5_nok", {buy_nok, buy_ok, credit}, {2'b10, 8'd3});
    buy(8'd0);
    check("buy0_nok", {buy_nok, credit}, {1'b1, 8'd3});

    // buy_req wins over payout_req
    payout_req = 1'b1; buy(8'd1); payout_req = 1'b0;
    check("buy_prio", {buy_ok, busy, credit}, {2'b10, 8'd2});

    // Timeout to FAULT (ACK_TIMEOUT = 8)
    repeat (4) ins(1, 0);
    check("acc_6", credit, 6);
    payout_req = 1'b1; step(); payout_req = 1'b0;
    step();
    check("tmo_req", pay_500, 1);
    ins(1, 0);
    check("wait_coin_rej", {coin_reject, credit}, {1'b1, 8'd6});
    buy(8'd1);
    check("wait_buy_nok", {buy_nok, buy_ok, credit}, {2'b10, 8'd6});
    repeat (5) step();
    check("tmo_still_req", {pay_500, fault}, 2'b10);
    step();
    check("tmo_fault", {pay_500, fault, busy}, 3'b011);
    check("tmo_credit", credit, 6);
    repeat (3) step();
    check("fault_hold", {fault, credit}, {1'b1, 8'd6});
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    check("fault_clr", {fault, busy, credit}, {2'b00, 8'd6});

    // Same-cycle purchase and coin, then reset mid-payout
    buy(8'd2);
    check("acc_4", credit, 4);
    price = 8'd4; buy_req = 1'b1; coin_100 = 1'b1;
    step();
    buy_req = 1'b0; coin_100 = 1'b0; price = '0;
    check("buy_coin", {buy_ok, coin_reject, credit}, {2'b10, 8'd1});
    payout_req = 1'b1; step(); payout_req = 1'b0;
    step();
    check("req_100_rst", pay_100, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {pay_100, busy, credit}, {2'b00, 8'd0});
    #3 rst = 1'b0;
    step();
    check("post_rst", {busy, credit}, {1'b0, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
